// File: rtl/sram_mem_controller_pkg.sv
// Shared types and constants for the MEM-stage to 16-bit asynchronous SRAM controller.
package sram_mem_controller_pkg;

  localparam int WORD_W           = 32;
  localparam int HALF_W           = 16;
  localparam int DEFAULT_MEM_BASE = 1024;
  localparam int CNT_W            = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Word offset of a byte address inside the SRAM window; callers truncate it to the SRAM span.
  function automatic logic [WORD_W-1:0] word_index(input logic [WORD_W-1:0] byte_addr,
                                                   input logic [WORD_W-1:0] base);
    return (byte_addr - base) >> 2;
  endfunction

endpackage

// File: rtl/sram_mem_controller.sv
// Splits each 32-bit MEM-stage load/store into a low then high 16-bit SRAM access,
// holding ready low until both halves have been on the bus for WAIT_CYCLES each.
module sram_mem_controller
  import sram_mem_controller_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int MEM_BASE    = DEFAULT_MEM_BASE,
  parameter int SRAM_AW     = 18
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic                rd_en,
  input  logic [WORD_W-1:0]   address,
  input  logic [WORD_W-1:0]   write_data,
  output logic [WORD_W-1:0]   read_data,
  output logic                ready,
  output logic [SRAM_AW-1:0]  sram_addr,
  output logic [HALF_W-1:0]   sram_dq_out,
  output logic                sram_dq_oe,
  input  logic [HALF_W-1:0]   sram_dq_in,
  output logic                sram_we_n
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYCLES - 1);

  state_t             state, next_state;
  logic [CNT_W-1:0]   counter, next_counter;

  logic               lat_wr;
  logic [WORD_W-1:0]  lat_addr;
  logic [WORD_W-1:0]  lat_data;

  logic               request;
  logic               phase_last;
  logic               src_wr;
  logic [WORD_W-1:0]  src_addr;
  logic [WORD_W-1:0]  src_data;
  logic [SRAM_AW-2:0] src_idx;

  logic [SRAM_AW-1:0] addr_d;
  logic [HALF_W-1:0]  dq_out_d;
  logic               dq_oe_d;
  logic               we_n_d;

  assign request    = wr_en | rd_en;
  assign phase_last = (counter == LAST_CNT);

  // In IDLE the request is being accepted this edge, so the bus values come
  // straight from the inputs; afterwards only the latched copies are trusted.
  assign src_wr   = (state == ST_IDLE) ? wr_en      : lat_wr;
  assign src_addr = (state == ST_IDLE) ? address    : lat_addr;
  assign src_data = (state == ST_IDLE) ? write_data : lat_data;
  assign src_idx  = (SRAM_AW-1)'(word_index(src_addr, WORD_W'(MEM_BASE)));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      counter <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      state   <= next_state;
      counter <= next_counter;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
    next_state   = state;
    next_counter = counter;
    unique case (state)
      ST_IDLE: begin
        if (request) begin
          next_state   = ST_LO;
          next_counter = '0;
        end
      end
      ST_LO: begin
        if (phase_last) begin
          next_state   = ST_HI;
          next_counter = '0;
        end else begin
          next_counter = counter + 1'b1;
        end
      end
      ST_HI: begin
        if (phase_last) begin
          next_state   = ST_DONE;
          next_counter = '0;
        end else begin
          next_counter = counter + 1'b1;
        end
      end
      ST_DONE: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state   = ST_IDLE;
        next_counter = '0;
      end
    endcase
  end

  // Output logic: ready is combinational, bus controls are decoded from the
  // next state and registered so the write strobe can never glitch.
  always_comb begin
    ready    = 1'b0;
    addr_d   = sram_addr;
    dq_out_d = sram_dq_out;
    dq_oe_d  = 1'b0;
    we_n_d   = 1'b1;

    unique case (state)
      ST_IDLE: ready = ~request;
      ST_DONE: ready = 1'b1;
      default: ready = 1'b0;
    endcase

    unique case (next_state)
      ST_LO: begin
        addr_d = {src_idx, 1'b0};
        if (src_wr) begin
          dq_out_d = src_data[HALF_W-1:0];
          dq_oe_d  = 1'b1;
          we_n_d   = 1'b0;
        end
      end
      ST_HI: begin
        addr_d = {src_idx, 1'b1};
        if (src_wr) begin
          dq_out_d = src_data[WORD_W-1:HALF_W];
          dq_oe_d  = 1'b1;
          we_n_d   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      sram_addr   <= addr_d;
      sram_dq_out <= dq_out_d;
      sram_dq_oe  <= dq_oe_d;
      sram_we_n   <= we_n_d;
    end
  end

  // Request capture; wr_en takes priority when both strobes are high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_wr   <= 1'b0;
      lat_addr <= '0;
      lat_data <= '0;
    end else if (state == ST_IDLE && request) begin
      lat_wr   <= wr_en;
      lat_addr <= address;
      lat_data <= write_data;
    end
  end

  // Each read half is captured on the last cycle it is held on the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_data <= '0;
    end else if (phase_last && !lat_wr) begin
      if (state == ST_LO) begin
        read_data[HALF_W-1:0] <= sram_dq_in;
      end else if (state == ST_HI) begin
        read_data[WORD_W-1:HALF_W] <= sram_dq_in;
      end
    end
  end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Randomized self-checking bench for sram_mem_controller against a word-level
// memory model and a cycle-numbered expectation of the two-half access sequence.
module tb_sram_mem_controller;

  localparam int W          = 2;
  localparam int AW         = 18;
  localparam int SPAN_WORDS = 1 << (AW - 1);
  localparam int DONE_CYC   = 2 * W + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en, rd_en;
  logic [31:0]   address, write_data;
  logic [31:0]   read_data;
  logic          ready;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_out;
  logic          sram_dq_oe;
  logic [15:0]   sram_dq_in;
  logic          sram_we_n;

  int checks   = 0;
  int failures = 0;

  logic [15:0] sram_mem [0:(1<<AW)-1];
  logic [31:0] ref_words [int];
  logic [31:0] exp_read_data;

  sram_mem_controller #(
    .WAIT_CYCLES(W),
    .MEM_BASE   (1024),
    .SRAM_AW    (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_oe (sram_dq_oe),
    .sram_dq_in (sram_dq_in),
    .sram_we_n  (sram_we_n)
  );

  always #5 clk = ~clk;

  // External SRAM: asynchronous read, write stored while the strobe is low.
  assign sram_dq_in = sram_mem[sram_addr];
  always @(posedge clk) begin
    if (sram_we_n === 1'b0) sram_mem[sram_addr] <= sram_dq_out;
  end

  function automatic int exp_idx(input logic [31:0] a);
    return int'(((a - 32'd1024) >> 2) % SPAN_WORDS);
  endfunction

  function automatic logic [31:0] ref_read(input int idx);
    return ref_words.exists(idx) ? ref_words[idx] : 32'h0;
  endfunction

  // One full access from the IDLE request cycle through DONE, then one idle cycle.
  task automatic run_access(input bit wr, input bit rd, input logic [31:0] addr,
                            input logic [31:0] data, input string name);
    int            idx;
    logic [AW-1:0] exp_addr;
    logic [15:0]   exp_dq;
    wr_en = wr; rd_en = rd; address = addr; write_data = data;
    idx = exp_idx(addr);
    if (wr) ref_words[idx] = data;
    else    exp_read_data  = ref_read(idx);
    #1;
    checks++;
    if (ready !== 1'b0) begin
      failures++;
      $display("FAIL %s cyc0 ready: got %b want 0", name, ready);
    end
    for (int k = 1; k <= DONE_CYC; k++) begin
      @(negedge clk);
      if (k < DONE_CYC) begin
        exp_addr = AW'(2 * idx + ((k > W) ? 1 : 0));
        exp_dq   = (k > W) ? data[31:16] : data[15:0];
        checks++;
        if (ready !== 1'b0 || sram_addr !== exp_addr) begin
          failures++;
          $display("FAIL %s cyc%0d ready/addr: got %b/%0h want 0/%0h", name, k, ready, sram_addr, exp_addr);
        end
        checks++;
        if (sram_we_n !== !wr || sram_dq_oe !== wr) begin
          failures++;
          $display("FAIL %s cyc%0d we_n/oe: got %b/%b want %b/%b", name, k, sram_we_n, sram_dq_oe, !wr, wr);
        end
        if (wr) begin
          checks++;
          if (sram_dq_out !== exp_dq) begin
            failures++;
            $display("FAIL %s cyc%0d dq_out: got %h want %h", name, k, sram_dq_out, exp_dq);
          end
        end
      end else begin
        checks++;
        if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
          failures++;
          $display("FAIL %s done ready/we_n/oe: got %b/%b/%b want 1/1/0", name, ready, sram_we_n, sram_dq_oe);
        end
        checks++;
        if (read_data !== exp_read_data) begin
          failures++;
          $display("FAIL %s read_data: got %h want %h", name, read_data, exp_read_data);
        end
      end
    end
    wr_en = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || sram_we_n !== 1'b1) begin
      failures++;
      $display("FAIL %s idle ready/we_n: got %b/%b want 1/1", name, ready, sram_we_n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
    exp_read_data = '0;
    #1;
    checks++;
    if (ready !== 1'b1 || read_data !== 32'h0 || sram_addr !== '0) begin
      failures++;
      $display("FAIL reset ready/read_data/addr: got %b/%h/%h want 1/0/0", ready, read_data, sram_addr);
    end
    checks++;
    if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || sram_dq_out !== 16'h0) begin
      failures++;
      $display("FAIL reset we_n/oe/dq_out: got %b/%b/%h want 1/0/0", sram_we_n, sram_dq_oe, sram_dq_out);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write();
    run_access(1'b1, 1'b0, 32'h0000_0400, 32'hDEAD_BEEF, "write");
  endtask

  task automatic test_read();
    run_access(1'b0, 1'b1, 32'h0000_0400, 32'h0, "read");
  endtask

  task automatic test_back_to_back();
    int            pulses = 0;
    int            idx1 = exp_idx(32'h404);
    int            idx2 = exp_idx(32'h408);
    logic [AW-1:0] exp_addr;
    wr_en = 1'b1; address = 32'h404; write_data = 32'h1111_2222;
    ref_words[idx1] = 32'h1111_2222;
    ref_words[idx2] = 32'h3333_4444;
    #1;
    if (ready === 1'b1) pulses++;
    for (int c = 1; c <= 2 * DONE_CYC + 1; c++) begin
      @(negedge clk);
      if (ready === 1'b1) pulses++;
      if (c != DONE_CYC && c != DONE_CYC + 1 && c != 2 * DONE_CYC + 1) begin
        if (c <= DONE_CYC) exp_addr = AW'(2 * idx1 + ((c > W) ? 1 : 0));
        else               exp_addr = AW'(2 * idx2 + ((c - DONE_CYC - 1 > W) ? 1 : 0));
        checks++;
        if (sram_addr !== exp_addr || sram_we_n !== 1'b0) begin
          failures++;
          $display("FAIL b2b cyc%0d addr/we_n: got %0h/%b want %0h/0", c, sram_addr, sram_we_n, exp_addr);
        end
      end
      if (c == DONE_CYC) begin
        address = 32'h408; write_data = 32'h3333_4444;
      end
      if (c == DONE_CYC + 1) begin
        checks++;
        if (ready !== 1'b0 || sram_we_n !== 1'b1) begin
          failures++;
          $display("FAIL b2b idle-gap ready/we_n: got %b/%b want 0/1", ready, sram_we_n);
        end
      end
      if (c == 2 * DONE_CYC + 1) wr_en = 1'b0;
    end
    checks++;
    if (pulses != 2) begin
      failures++;
      $display("FAIL b2b ready pulses: got %0d want 2", pulses);
    end
    @(negedge clk);
    run_access(1'b0, 1'b1, 32'h404, 32'h0, "b2b_rd1");
    run_access(1'b0, 1'b1, 32'h408, 32'h0, "b2b_rd2");
  endtask

  task automatic test_both_strobes();
    run_access(1'b1, 1'b1, 32'h0000_0410, 32'hCAFE_F00D, "both");
    run_access(1'b0, 1'b1, 32'h0000_0410, 32'h0, "both_rd");
  endtask

  task automatic test_reset_mid_write();
    wr_en = 1'b1; address = 32'h0000_0440; write_data = 32'h5555_AAAA;
    repeat (W + 1) @(negedge clk);
    checks++;
    if (sram_we_n !== 1'b0 || sram_addr !== AW'(2 * exp_idx(32'h440) + 1)) begin
      failures++;
      $display("FAIL rst_mid pre we_n/addr: got %b/%0h want 0/%0h", sram_we_n, sram_addr,
               2 * exp_idx(32'h440) + 1);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || sram_addr !== '0 || ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid async we_n/oe/addr/ready: got %b/%b/%0h/%b want 1/0/0/0",
               sram_we_n, sram_dq_oe, sram_addr, ready);
    end
    wr_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_read_data = '0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || read_data !== 32'h0 || sram_we_n !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid after ready/read_data/we_n: got %b/%h/%b want 1/0/1", ready, read_data, sram_we_n);
    end
  endtask

  task automatic test_wrap();
    run_access(1'b1, 1'b0, 32'h0008_0400, 32'h0BAD_F00D, "wrap_wr");
    run_access(1'b0, 1'b1, 32'h0000_0400, 32'h0, "wrap_rd");
  endtask

  task automatic test_random();
    logic [31:0] a;
    bit          wr;
    for (int i = 0; i < 30; i++) begin
      wr = bit'($urandom_range(0, 1));
      a  = 32'h400 + 32'(4 * $urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) a = a + 32'h0008_0000;
      run_access(wr, !wr, a, $urandom, $sformatf("rand%0d", i));
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) sram_mem[i] = 16'h0;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_both_strobes();
    test_reset_mid_write();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
